// File: rtl/uart_transmitter.sv
// UART transmitter: one-entry holding buffer fed by a valid/ready handshake,
// serialising 8-bit LSB-first frames with optional parity and 1 or 2 stop bits.
// Bit period is comp+1 clk cycles. comp is read live.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle high, waiting for the holding buffer to fill
// ST_START  | start bit (0)
// ST_DATA   | 8 data bits, LSB first, bit_idx counts 0..7
// ST_PARITY | parity bit (only reached when PARITY_EN=1)
// ST_STOP   | STOP_BITS stop bits (1)

module uart_transmitter #(
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        tr_en,
   input  logic [15:0] comp,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        uart_tx
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic PAR_ON   = (PARITY_EN != 0);
   localparam logic PAR_ODD  = (PARITY_ODD != 0);
   localparam logic TWO_STOP = (STOP_BITS == 2);

   state_t      state_q, state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        stop_cnt_q, stop_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        parity_q, parity_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic        tx_q, tx_d;

   logic        accept;
   logic        bit_end;
   logic        last_stop;
   logic        load;

   // Ready is gated by rstn so it reads 0 for the whole reset window.
   assign tx_ready  = rstn && tr_en && !hold_full_q;
   assign accept    = tx_valid && tx_ready;
   // >= rather than == so a mid-frame comp decrease can never strand the counter.
   assign bit_end   = (state_q != ST_IDLE) && (baud_cnt_q >= comp);
   assign last_stop = !TWO_STOP || stop_cnt_q;
   // Done is gated by tr_en so an abort landing on the final cycle reports nothing.
   assign tx_done   = tr_en && (state_q == ST_STOP) && bit_end && last_stop;
   assign tx_busy   = (state_q != ST_IDLE);
   assign uart_tx   = tx_q;

   // Next-state, counters, holding buffer and next line value.
   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_idx_d   = bit_idx_q;
      stop_cnt_d  = stop_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      load        = 1'b0;
      tx_d        = 1'b1;

      if (state_q != ST_IDLE) begin
         baud_cnt_d = bit_end ? 16'd0 : baud_cnt_q + 16'd1;
      end

      if (accept) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (hold_full_q) begin
               load = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  stop_cnt_d = 1'b0;
                  if (PAR_ON) begin
                     state_d = ST_PARITY;
                  end else begin
                     state_d = ST_STOP;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d    = ST_STOP;
               stop_cnt_d = 1'b0;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (last_stop) begin
                  // A waiting byte starts immediately, keeping frames gapless.
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         state_d     = ST_START;
         shift_d     = hold_q;
         parity_d    = (^hold_q) ^ PAR_ODD;
         hold_full_d = 1'b0;
         bit_idx_d   = 3'd0;
         stop_cnt_d  = 1'b0;
      end

      if (!tr_en) begin
         state_d     = ST_IDLE;
         baud_cnt_d  = 16'd0;
         bit_idx_d   = 3'd0;
         stop_cnt_d  = 1'b0;
         hold_full_d = 1'b0;
      end

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = parity_q;
         default:   tx_d = 1'b1;
      endcase
   end

   // State, counters and registered line output.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         baud_cnt_q  <= 16'd0;
         bit_idx_q   <= 3'd0;
         stop_cnt_q  <= 1'b0;
         shift_q     <= 8'd0;
         parity_q    <= 1'b0;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         stop_cnt_q  <= stop_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter. Three instances cover the configurations:
// 0: no parity, 1 stop; 1: even parity, 2 stop; 2: odd parity, 2 stop.
// A frame-level model (bit vector + cycle index) predicts every output each cycle.

module tb_uart_transmitter;

   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rstn;
   logic         tr_en;
   logic [15:0]  comp;
   logic [7:0]   tx_data;
   logic [N-1:0] tx_valid;
   logic [N-1:0] tx_ready_w;
   logic [N-1:0] tx_busy_w;
   logic [N-1:0] tx_done_w;
   logic [N-1:0] uart_tx_w;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      uart_transmitter #(
         .PARITY_EN ((g > 0) ? 1 : 0),
         .PARITY_ODD((g == 2) ? 1 : 0),
         .STOP_BITS ((g > 0) ? 2 : 1)
      ) u_dut (
         .clk     (clk),
         .rstn    (rstn),
         .tr_en   (tr_en),
         .comp    (comp),
         .tx_data (tx_data),
         .tx_valid(tx_valid[g]),
         .tx_ready(tx_ready_w[g]),
         .tx_busy (tx_busy_w[g]),
         .tx_done (tx_done_w[g]),
         .uart_tx (uart_tx_w[g])
      );
   end

   int n_vec = 0;
   int n_err = 0;

   function automatic bit par_en(int i);
      return i > 0;
   endfunction

   function automatic bit par_odd(int i);
      return i == 2;
   endfunction

   function automatic int stops(int i);
      return (i > 0) ? 2 : 1;
   endfunction

   // Frame as transmitted: bit 0 goes out first.
   function automatic bit [11:0] make_frame(int i, bit [7:0] d);
      bit [11:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int j = 0; j < 8; j++) f[1+j] = d[j];
      if (par_en(i)) f[9] = (^d) ^ par_odd(i);
      return f;
   endfunction

   function automatic void chk(string nm, int i, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   bit        act_m   [N];
   bit [11:0] frame_m [N];
   int        len_m   [N];
   int        per_m   [N];
   int        k_m     [N];
   bit        hold_m  [N];
   bit [7:0]  hbyte_m [N];
   int        acc_m   [N];

   // Model advances on the same edge as the DUT, from inputs only.
   always @(posedge clk or negedge rstn) begin
      bit hold_old;
      if (!rstn) begin
         for (int i = 0; i < N; i++) begin
            act_m[i]  = 1'b0;
            hold_m[i] = 1'b0;
            k_m[i]    = 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            hold_old = hold_m[i];
            if (!tr_en) begin
               act_m[i]  = 1'b0;
               hold_m[i] = 1'b0;
            end else begin
               if (act_m[i]) begin
                  k_m[i]++;
                  if (k_m[i] == len_m[i] * per_m[i]) act_m[i] = 1'b0;
               end
               if (!act_m[i] && hold_old) begin
                  frame_m[i] = make_frame(i, hbyte_m[i]);
                  len_m[i]   = 10 + int'(par_en(i)) + stops(i) - 1;
                  per_m[i]   = int'(comp) + 1;
                  k_m[i]     = 0;
                  act_m[i]   = 1'b1;
                  hold_m[i]  = 1'b0;
               end
               if (tx_valid[i] && !hold_old) begin
                  hold_m[i]  = 1'b1;
                  hbyte_m[i] = tx_data;
                  acc_m[i]++;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare + bookkeeping ----------------
   int          busy_cnt [N];
   int          done_cnt [N];
   int          busy_run [N];
   int          busy_max [N];
   logic [63:0] rec      [N];
   int          done_t0  [8];
   int          dn0 = 0;
   int          cyc = 0;

   // Checks every output of every instance against the model each cycle.
   always @(negedge clk) begin
      logic e_tx, e_busy, e_done, e_ready;
      for (int i = 0; i < N; i++) begin
         if (act_m[i]) begin
            e_tx   = frame_m[i][k_m[i] / per_m[i]];
            e_busy = 1'b1;
            e_done = (k_m[i] == len_m[i] * per_m[i] - 1) && tr_en;
         end else begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
            e_done = 1'b0;
         end
         e_ready = rstn && tr_en && !hold_m[i];
         chk("uart_tx", i, 64'(uart_tx_w[i]), 64'(e_tx));
         chk("tx_busy", i, 64'(tx_busy_w[i]), 64'(e_busy));
         chk("tx_done", i, 64'(tx_done_w[i]), 64'(e_done));
         chk("tx_ready", i, 64'(tx_ready_w[i]), 64'(e_ready));
         if (tx_busy_w[i]) begin
            busy_cnt[i]++;
            busy_run[i]++;
            if (busy_run[i] > busy_max[i]) busy_max[i] = busy_run[i];
            rec[i] = {rec[i][62:0], uart_tx_w[i]};
         end else begin
            busy_run[i] = 0;
         end
         if (tx_done_w[i]) done_cnt[i]++;
      end
      if (tx_done_w[0]) begin
         if (dn0 < 8) done_t0[dn0] = cyc;
         dn0++;
      end
      cyc++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc_wait(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_stats();
      for (int i = 0; i < N; i++) begin
         busy_cnt[i] = 0;
         done_cnt[i] = 0;
         busy_run[i] = 0;
         busy_max[i] = 0;
         rec[i]      = '0;
      end
      dn0 = 0;
   endtask

   task automatic send(int i, logic [7:0] d);
      int t;
      t = 0;
      while (!(tr_en && !hold_m[i]) && t < 2000) begin
         cyc_wait(1);
         t++;
      end
      chk("send_timeout", i, 64'(t < 2000), 64'd1);
      tx_data     = d;
      tx_valid[i] = 1'b1;
      cyc_wait(1);
      tx_valid[i] = 1'b0;
   endtask

   task automatic wait_idle(int i);
      int t;
      t = 0;
      while ((act_m[i] || hold_m[i]) && t < 3000) begin
         cyc_wait(1);
         t++;
      end
      chk("idle_timeout", i, 64'(t < 3000), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] exp;
      logic [9:0]  seq10;
      logic [19:0] seq20;
      logic [7:0]  tbytes [4];
      int          idx, t, a0;

      rstn     = 1'b1;
      tr_en    = 1'b1;
      comp     = 16'd3;
      tx_data  = 8'h00;
      tx_valid = '0;
      #1 rstn  = 1'b0;
      #1;
      chk("rst_uart_tx", 0, 64'(uart_tx_w[0]), 64'd1);
      chk("rst_busy", 0, 64'(tx_busy_w[0]), 64'd0);
      chk("rst_done", 0, 64'(tx_done_w[0]), 64'd0);
      chk("rst_ready", 0, 64'(tx_ready_w[0]), 64'd0);
      cyc_wait(3);
      rstn = 1'b1;
      cyc_wait(2);

      // model pins
      chk("model_frame_a5", 0, 64'(make_frame(0, 8'hA5)), 64'h0F4A);
      chk("model_frame_07e", 1, 64'(make_frame(1, 8'h07)), 64'h0E0E);
      chk("model_frame_07o", 2, 64'(make_frame(2, 8'h07)), 64'h0C0E);

      // single byte, comp=3
      clear_stats();
      comp = 16'd3;
      send(0, 8'hA5);
      cyc_wait(45);
      seq10 = 10'b0101001011;
      exp   = '0;
      for (int j = 0; j < 10; j++)
         for (int c = 0; c < 4; c++) exp = {exp[62:0], seq10[9-j]};
      chk("a5_wave", 0, {24'd0, rec[0][39:0]}, exp);
      chk("a5_busy", 0, 64'(busy_cnt[0]), 64'd40);
      chk("a5_done", 0, 64'(done_cnt[0]), 64'd1);

      // back-to-back, comp=1
      clear_stats();
      comp = 16'd1;
      send(0, 8'h00);
      cyc_wait(5);
      send(0, 8'hFF);
      chk("b2b_ready_low", 0, 64'(tx_ready_w[0]), 64'd0);
      cyc_wait(50);
      seq20 = 20'b0000000001_0111111111;
      exp   = '0;
      for (int j = 0; j < 20; j++)
         for (int c = 0; c < 2; c++) exp = {exp[62:0], seq20[19-j]};
      chk("b2b_wave", 0, {24'd0, rec[0][39:0]}, exp);
      chk("b2b_busy_run", 0, 64'(busy_max[0]), 64'd40);
      chk("b2b_done", 0, 64'(done_cnt[0]), 64'd2);

      // parity + 2 stop bits, comp=0
      clear_stats();
      comp = 16'd0;
      send(1, 8'h07);
      cyc_wait(16);
      send(2, 8'h07);
      cyc_wait(16);
      chk("par_even_wave", 1, 64'(rec[1][11:0]), 64'b011100000111);
      chk("par_odd_wave", 2, 64'(rec[2][11:0]), 64'b011100000011);
      chk("par_busy", 1, 64'(busy_cnt[1]), 64'd12);
      chk("par_done", 2, 64'(done_cnt[2]), 64'd1);

      // abort during data bit 3, comp=7
      clear_stats();
      comp = 16'd7;
      send(0, 8'h55);
      cyc_wait(34);
      tr_en = 1'b0;
      cyc_wait(1);
      chk("abort_tx", 0, 64'(uart_tx_w[0]), 64'd1);
      chk("abort_busy", 0, 64'(tx_busy_w[0]), 64'd0);
      chk("abort_ready", 0, 64'(tx_ready_w[0]), 64'd0);
      cyc_wait(3);
      chk("abort_no_done", 0, 64'(done_cnt[0]), 64'd0);
      tr_en = 1'b1;
      clear_stats();
      send(0, 8'h3C);
      cyc_wait(85);
      chk("reen_busy_run", 0, 64'(busy_max[0]), 64'd80);
      chk("reen_done", 0, 64'(done_cnt[0]), 64'd1);

      // async reset mid-frame with a second byte waiting
      comp = 16'd3;
      send(0, 8'h11);
      send(0, 8'h22);
      cyc_wait(8);
      #1 rstn = 1'b0;
      #1;
      chk("arst_tx", 0, 64'(uart_tx_w[0]), 64'd1);
      chk("arst_busy", 0, 64'(tx_busy_w[0]), 64'd0);
      cyc_wait(2);
      rstn = 1'b1;
      clear_stats();
      cyc_wait(6);
      chk("arst_flushed_busy", 0, 64'(busy_cnt[0]), 64'd0);
      chk("arst_ready", 0, 64'(tx_ready_w[0]), 64'd1);

      // throttle: valid held for 4 bytes, comp=2
      clear_stats();
      comp = 16'd2;
      for (int j = 0; j < 4; j++) tbytes[j] = 8'($urandom);
      a0          = acc_m[0];
      idx         = 0;
      t           = 0;
      tx_data     = tbytes[0];
      tx_valid[0] = 1'b1;
      while (idx < 4 && t < 500) begin
         cyc_wait(1);
         t++;
         if (acc_m[0] - a0 > idx) begin
            idx++;
            if (idx < 4) tx_data = tbytes[idx];
         end
      end
      tx_valid[0] = 1'b0;
      chk("thr_accepts", 0, 64'(acc_m[0] - a0), 64'd4);
      cyc_wait(130);
      chk("thr_done", 0, 64'(done_cnt[0]), 64'd4);
      for (int j = 1; j < 4; j++)
         chk("thr_gap", j, 64'(done_t0[j] - done_t0[j-1]), 64'd30);

      // randomized traffic on every configuration
      for (int i = 0; i < N; i++) begin
         for (int b = 0; b < 2; b++) begin
            wait_idle(i);
            comp = 16'($urandom_range(0, 3));
            for (int n = 0; n < 10; n++) begin
               send(i, 8'($urandom));
               cyc_wait($urandom_range(0, 12));
            end
         end
         wait_idle(i);
      end
      cyc_wait(60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
